// File: rtl/seq_pkg.sv
// Shared definitions for the symbol-sequence generator: FSM state encoding,
// pattern-select codes, the three pattern symbol triples and the idle symbol.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [1:0] PAT_SEL_P0   = 2'd0;
  localparam logic [1:0] PAT_SEL_P1   = 2'd1;
  localparam logic [1:0] PAT_SEL_P2   = 2'd2;
  localparam logic [1:0] PAT_SEL_RSVD = 2'd3;

  // Each triple is packed with symbol 0 in the top two bits, as {B,A} pairs.
  localparam logic [5:0] PAT_P0_SYMS = {2'b01, 2'b11, 2'b01};
  localparam logic [5:0] PAT_P1_SYMS = {2'b00, 2'b11, 2'b10};
  localparam logic [5:0] PAT_P2_SYMS = {2'b01, 2'b11, 2'b00};

  localparam logic [1:0] IDLE_SYM_DEFAULT = 2'b11;

  localparam logic [1:0] LAST_IDX = 2'd2;

  // Maps a pattern-select code to its packed symbol triple; the reserved
  // code yields idle symbols so a stray lookup never looks like a pattern.
  function automatic logic [5:0] pat_word(input logic [1:0] sel);
    logic [5:0] word;
    case (sel)
      PAT_SEL_P0: word = PAT_P0_SYMS;
      PAT_SEL_P1: word = PAT_P1_SYMS;
      PAT_SEL_P2: word = PAT_P2_SYMS;
      default:    word = {3{IDLE_SYM_DEFAULT}};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Control and symbol bus of the sequence generator. The master side issues
// burst requests and watches the symbol stream; the slave side is seq_gen.
interface seq_gen_if;

  logic       start;
  logic       stop;
  logic [1:0] pat_sel;
  logic [3:0] rep;
  logic [3:0] gap;
  logic       A;
  logic       B;
  logic       valid;
  logic       busy;
  logic       done;
  logic       err;
  logic       expect_z;

  modport master (
    output start, stop, pat_sel, rep, gap,
    input  A, B, valid, busy, done, err, expect_z
  );

  modport slave (
    input  start, stop, pat_sel, rep, gap,
    output A, B, valid, busy, done, err, expect_z
  );

endinterface

// File: rtl/seq_pat_rom.sv
// Combinational pattern table: returns the {B,A} symbol at a given index of
// the selected pattern, and flags the final symbol of the triple.
module seq_pat_rom
  import seq_pkg::*;
(
  input  logic [1:0] pat_sel,
  input  logic [1:0] idx,
  output logic [1:0] sym,
  output logic       last
);

  logic [5:0] word;

  // Look up the triple and pick the symbol addressed by idx.
  always_comb begin
    word = pat_word(pat_sel);
    case (idx)
      2'd0:    sym = word[5:4];
      2'd1:    sym = word[3:2];
      default: sym = word[1:0];
    endcase
    last = (idx == LAST_IDX);
  end

endmodule

// File: rtl/seq_gen.sv
// Burst symbol generator. A burst is rep+1 repetitions of a three-symbol
// pattern, separated by gap idle cycles, followed by a one-cycle done pulse.
// Every output is a flop; next-state and next-output values are computed
// together so each output appears in the same cycle as the state it reflects.
module seq_gen
  import seq_pkg::*;
#(
  parameter logic [1:0] IDLE_SYM = IDLE_SYM_DEFAULT
) (
  input  logic      clk,
  input  logic      clr,
  seq_gen_if.slave  bus
);

  state_e     state_q, state_d;
  logic [1:0] pat_q, pat_d;
  logic [3:0] rep_q, rep_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [1:0] idx_q, idx_d;

  logic [1:0] sym_q, sym_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       expect_z_q, expect_z_d;

  logic [1:0] rom_pat;
  logic [1:0] rom_idx;
  logic [1:0] rom_sym;
  logic       rom_last;

  seq_pat_rom u_rom (
    .pat_sel (rom_pat),
    .idx     (rom_idx),
    .sym     (rom_sym),
    .last    (rom_last)
  );

  // Address the ROM with the symbol that will be shown after the next edge:
  // the incoming selection while idle, otherwise the latched pattern.
  always_comb begin
    rom_pat = (state_q == ST_IDLE) ? bus.pat_sel : pat_q;
    rom_idx = (state_q == ST_SEND && idx_q != LAST_IDX) ? idx_q + 2'd1 : 2'd0;
  end

  // Next-state and next-output decision for the burst FSM.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    sym_d      = IDLE_SYM;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    expect_z_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.pat_sel != PAT_SEL_RSVD) begin
            state_d    = ST_SEND;
            pat_d      = bus.pat_sel;
            rep_d      = bus.rep;
            gap_d      = bus.gap;
            gap_cnt_d  = 4'd0;
            idx_d      = 2'd0;
            sym_d      = rom_sym;
            valid_d    = 1'b1;
            busy_d     = 1'b1;
            expect_z_d = rom_last;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (bus.stop) begin
          state_d   = ST_IDLE;
          idx_d     = 2'd0;
          gap_cnt_d = 4'd0;
          rep_d     = 4'd0;
        end else if (idx_q != LAST_IDX) begin
          idx_d      = idx_q + 2'd1;
          sym_d      = rom_sym;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          expect_z_d = rom_last;
        end else if (rep_q == 4'd0) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          done_d  = 1'b1;
        end else begin
          rep_d = rep_q - 4'd1;
          idx_d = 2'd0;
          if (gap_q != 4'd0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
            busy_d    = 1'b1;
          end else begin
            sym_d      = rom_sym;
            valid_d    = 1'b1;
            busy_d     = 1'b1;
            expect_z_d = rom_last;
          end
        end
      end

      ST_GAP: begin
        if (bus.stop) begin
          state_d   = ST_IDLE;
          idx_d     = 2'd0;
          gap_cnt_d = 4'd0;
          rep_d     = 4'd0;
        end else if (gap_cnt_q <= 4'd1) begin
          state_d    = ST_SEND;
          gap_cnt_d  = 4'd0;
          idx_d      = 2'd0;
          sym_d      = rom_sym;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          expect_z_d = rom_last;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
          busy_d    = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register state, counters and all outputs; clr returns everything to idle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      pat_q      <= 2'd0;
      rep_q      <= 4'd0;
      gap_q      <= 4'd0;
      gap_cnt_q  <= 4'd0;
      idx_q      <= 2'd0;
      sym_q      <= IDLE_SYM;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      expect_z_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      rep_q      <= rep_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      sym_q      <= sym_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      expect_z_q <= expect_z_d;
    end
  end

  assign bus.A        = sym_q[0];
  assign bus.B        = sym_q[1];
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.expect_z = expect_z_q;

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter IDLE_SYM, default 2'b11, meaning the {B,A} value driven while no symbol is valid.
REQ-002 The block SHALL have input clk, 1 bit, the clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have input clr, 1 bit, reset, asynchronous, active-high.
REQ-004 The block SHALL have input start, 1 bit, a request to begin a burst.
REQ-005 The block SHALL have input stop, 1 bit, a synchronous abort of a burst in progress.
REQ-006 The block SHALL have input pat_sel, 2 bits, the pattern select: 0=P0, 1=P1, 2=P2, 3=reserved.
REQ-007 The block SHALL have input rep, 4 bits, the repetition count; the burst contains rep+1 patterns.
REQ-008 The block SHALL have input gap, 4 bits, the number of idle cycles inserted between patterns.
REQ-009 The block SHALL have outputs A and B, 1 bit each, the registered symbol, with symbol = {B,A}.
REQ-010 The block SHALL have output valid, 1 bit, high while {B,A} carries a pattern symbol.
REQ-011 The block SHALL have output busy, 1 bit, high while a burst is in progress.
REQ-012 The block SHALL have output done, 1 bit, a one-cycle pulse marking burst completion.
REQ-013 The block SHALL have output err, 1 bit, a one-cycle pulse when start is rejected because pat_sel=3.
REQ-014 The block SHALL have output expect_z, 1 bit, high on the cycle where a downstream sequence detector must assert Z.

Function
REQ-015 The patterns SHALL be the following {B,A} symbol triples: P0 = 01,11,01; P1 = 00,11,10; P2 = 01,11,00.
REQ-016 The FSM SHALL have states IDLE, SEND, GAP.
REQ-017 In IDLE, start=1 with pat_sel<3 SHALL latch pat_sel, rep and gap, and then show symbol 0 in the next cycle (1-cycle latency).
REQ-018 In SEND, the FSM SHALL present one symbol per cycle with valid=1, using a symbol index that counts 0,1,2.
REQ-019 After symbol 2 of a non-final pattern, the FSM SHALL go to GAP for gap cycles if gap>0, otherwise directly to symbol 0 of the next pattern.
REQ-020 In GAP, the outputs SHALL be {B,A}=IDLE_SYM with valid=0.
REQ-021 The gap counter SHALL count down from the latched gap value to 1.
REQ-022 After symbol 2 of the final pattern, the FSM SHALL go to IDLE, and done SHALL pulse in that first IDLE cycle; no trailing gap is inserted.
REQ-023 expect_z SHALL be 1 exactly on every symbol-2 cycle and 0 otherwise.
REQ-024 busy SHALL be 1 in SEND and GAP, and 0 in IDLE, including the done cycle.
REQ-025 A burst SHALL occupy exactly 3*(rep+1) + rep*gap cycles.
REQ-026 start while busy=1 SHALL be ignored, with no effect on the latched values.
REQ-027 start in the done cycle SHALL be accepted normally.
REQ-028 start with pat_sel=3 in IDLE SHALL leave the FSM in IDLE and pulse err in the next cycle.
REQ-029 stop=1 in SEND or GAP SHALL force IDLE at the next edge with no done pulse; stop has priority over start.
REQ-030 The repetition counter SHALL count down without wrap, and rep=15 SHALL yield 16 patterns.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-032 clr=1 SHALL asynchronously force state IDLE, all counters 0, {B,A}=IDLE_SYM, and valid, busy, done, err and expect_z to 0.
REQ-033 clr asserted mid-burst SHALL abandon the burst with no done pulse, and the first start after clr deasserts SHALL behave as from power-up.

Structure
REQ-034 Shared package seq_pkg SHALL hold the state encodings, the pattern-select codes, the three pattern symbol constants and the IDLE_SYM default.
REQ-035 Sub-module seq_pat_rom SHALL be a combinational lookup from (pat_sel, index) to the 2-bit symbol and last-symbol flag, instantiated once.

Verification
REQ-036 P0, rep=0, gap=0, start at cycle 0 SHALL give {B,A}=01,11,01 in cycles 1-3, valid=1, expect_z in cycle 3, and done in cycle 4.
REQ-037 P1, rep=1, gap=2 SHALL give cycles 1-8 = 00,11,10,11,11,00,11,10 with valid=0 in cycles 4-5, expect_z in cycles 3 and 8, and done in cycle 9.
REQ-038 pat_sel=3 with start SHALL give err=1 in cycle 1, busy=0, and {B,A}=11.
REQ-039 P2, rep=2, with stop in cycle 2 SHALL give cycle 3 {B,A}=11, valid=0, busy=0, and no done; start in cycle 2 with stop SHALL be ignored.
REQ-040 A second start during a burst, and clr mid-burst, SHALL respectively give an unchanged symbol stream and immediate idle outputs with no done.
REQ-041 The bench SHALL connect the existing detector downstream and check for each of P0, P1, P2 that its Z equals expect_z on every cycle.
